// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared definitions for the pipelined-core run controller.
//   run_state_e : controller FSM encoding (Idle=0, RstHold=1, Run=2, Done=3)
//   DefPcW      : default retire-PC width
//   DefCntW     : default cycle/retire counter width
// -----------------------------------------------------------------------------
package pipeline_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRstHold = 2'd1,
        StRun     = 2'd2,
        StDone    = 2'd3
    } run_state_e;

    localparam int unsigned DefPcW  = 32;
    localparam int unsigned DefCntW = 32;

endpackage

// File: rtl/pipeline_halt_det.sv
// -----------------------------------------------------------------------------
// pipeline_halt_det
// Per-core halt detector and retire counter. A core is considered halted once
// it retires the same PC HALT_REPEAT times in a row (a branch-to-self loop).
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   clr          in   synchronous clear of all state (run restart)
//   en           in   retire inputs are only observed while en=1
//   retire_valid in   core retired an instruction this cycle
//   retire_pc    in   PC of the retired instruction
//   halted       out  sticky halt flag (registered)
//   halted_next  out  next-state of halted, lets the top see a halt one cycle early
//   retire_count out  saturating retire counter (registered)
// -----------------------------------------------------------------------------
module pipeline_halt_det
    import pipeline_pkg::*;
#(
    parameter int unsigned HALT_REPEAT = 4,
    parameter int unsigned PC_W        = DefPcW,
    parameter int unsigned CNT_W       = DefCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             retire_valid,
    input  logic [PC_W-1:0]  retire_pc,
    output logic             halted,
    output logic             halted_next,
    output logic [CNT_W-1:0] retire_count
);

    localparam int unsigned   RepW   = $clog2(HALT_REPEAT + 1);
    localparam logic [RepW-1:0] RepMax = RepW'(HALT_REPEAT);
    localparam logic [RepW-1:0] RepOne = RepW'(1);

    logic [PC_W-1:0]  last_pc_q, last_pc_d;
    logic [RepW-1:0]  rep_q, rep_d;
    logic             seen_q, seen_d;   // last_pc_q holds a PC from this run
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

    always_comb begin
        last_pc_d = last_pc_q;
        rep_d     = rep_q;
        seen_d    = seen_q;
        halted_d  = halted_q;
        ret_cnt_d = ret_cnt_q;
        if (clr) begin
            last_pc_d = '0;
            rep_d     = '0;
            seen_d    = 1'b0;
            halted_d  = 1'b0;
            ret_cnt_d = '0;
        end else if (en && retire_valid) begin
            if (ret_cnt_q != '1) begin
                ret_cnt_d = ret_cnt_q + 1'b1;
            end
            // Without seen_q a stale PC from the previous run could extend a streak.
            if (seen_q && (retire_pc == last_pc_q)) begin
                if (rep_q != RepMax) begin
                    rep_d = rep_q + 1'b1;
                end
            end else begin
                rep_d     = RepOne;
                last_pc_d = retire_pc;
            end
            seen_d = 1'b1;
            if (rep_d == RepMax) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_pc_q <= '0;
            rep_q     <= '0;
            seen_q    <= 1'b0;
            halted_q  <= 1'b0;
            ret_cnt_q <= '0;
        end else begin
            last_pc_q <= last_pc_d;
            rep_q     <= rep_d;
            seen_q    <= seen_d;
            halted_q  <= halted_d;
            ret_cnt_q <= ret_cnt_d;
        end
    end

    assign halted       = halted_q;
    assign halted_next  = halted_d;
    assign retire_count = ret_cnt_q;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_run_ctrl
// Run controller for NUM_CORES pipelined cores: holds the cores in reset for
// RST_HOLD cycles after start, runs them for at most MAX_CYCLES cycles, counts
// cycles and retirements, and finishes early once every core has halted.
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   start        in   1-cycle start request (honoured in Idle and Done)
//   retire_valid in   [NUM_CORES] per-core retire strobe
//   retire_pc    in   [NUM_CORES*PC_W] per-core retire PC, core i at [i*PC_W +: PC_W]
//   core_rst_n   out  [NUM_CORES] active-low core reset, released only in Run
//   busy         out  1 in RstHold or Run
//   done         out  1 in Done
//   timeout      out  run ended on the cycle budget rather than on halts
//   halted       out  [NUM_CORES] sticky per-core halt flags
//   cycle_count  out  [CNT_W] cycles spent in Run (saturating)
//   retire_count out  [NUM_CORES*CNT_W] per-core retire counts, sliced like retire_pc
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module pipeline_run_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 1,
    parameter int unsigned RST_HOLD    = 2,
    parameter int unsigned MAX_CYCLES  = 50,
    parameter int unsigned HALT_REPEAT = 4,
    parameter int unsigned PC_W        = DefPcW,
    parameter int unsigned CNT_W       = DefCntW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_CORES-1:0]       retire_valid,
    input  logic [NUM_CORES*PC_W-1:0]  retire_pc,
    output logic [NUM_CORES-1:0]       core_rst_n,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [NUM_CORES-1:0]       halted,
    output logic [CNT_W-1:0]           cycle_count,
    output logic [NUM_CORES*CNT_W-1:0] retire_count
);

    localparam int unsigned      HoldW    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HoldW-1:0] HoldInit = HoldW'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] CycLast  = CNT_W'(MAX_CYCLES - 1);

    run_state_e             state_q, state_d;
    logic [HoldW-1:0]       hold_q, hold_d;
    logic [CNT_W-1:0]       cycle_q, cycle_d;
    logic                   timeout_q, timeout_d;
    logic [NUM_CORES-1:0]   core_rst_n_q, core_rst_n_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   start_ok;
    logic                   clr;
    logic                   run_en;
    logic [NUM_CORES-1:0]   halted_next;
    logic                   all_halted_next;

    // Clear is derived from state_q/start rather than state_d: state_d depends on
    // the detectors' halted_next, which in turn depends on clr.
    assign start_ok        = start && ((state_q == StIdle) || (state_q == StDone));
    assign clr             = start_ok || (state_q == StRstHold);
    assign run_en          = (state_q == StRun);
    assign all_halted_next = &halted_next;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        pipeline_halt_det #(
            .HALT_REPEAT (HALT_REPEAT),
            .PC_W        (PC_W),
            .CNT_W       (CNT_W)
        ) u_halt_det (
            .clk          (clk),
            .rst          (rst),
            .clr          (clr),
            .en           (run_en),
            .retire_valid (retire_valid[i]),
            .retire_pc    (retire_pc[i*PC_W +: PC_W]),
            .halted       (halted[i]),
            .halted_next  (halted_next[i]),
            .retire_count (retire_count[i*CNT_W +: CNT_W])
        );
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        cycle_d   = cycle_q;
        timeout_d = timeout_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StRstHold;
                    hold_d    = HoldInit;
                    cycle_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            StRstHold: begin
                cycle_d   = '0;
                timeout_d = 1'b0;
                if (hold_q == '0) begin
                    state_d = StRun;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            StRun: begin
                if (cycle_q != '1) begin
                    cycle_d = cycle_q + 1'b1;
                end
                // A halt completing on the last budget cycle is not a timeout.
                if (all_halted_next) begin
                    state_d   = StDone;
                    timeout_d = 1'b0;
                end else if (cycle_q == CycLast) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        core_rst_n_d = (state_d == StRun) ? {NUM_CORES{1'b1}} : {NUM_CORES{1'b0}};
        busy_d       = (state_d == StRstHold) || (state_d == StRun);
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            hold_q       <= '0;
            cycle_q      <= '0;
            timeout_q    <= 1'b0;
            core_rst_n_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            cycle_q      <= cycle_d;
            timeout_q    <= timeout_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign core_rst_n  = core_rst_n_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_run_ctrl
// Bench for pipeline_run_ctrl: a single-core instance driven from a table of
// retire-PC runs, and a two-core instance exercised with hand-written runs
// (partial halt, halt on the last budget cycle, restart, mid-run reset).
// -----------------------------------------------------------------------------
module tb_pipeline_run_ctrl;

    localparam int unsigned HOLD = 2;
    localparam int unsigned MAXC = 50;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Single-core instance
    logic        start1;
    logic [0:0]  rv1;
    logic [31:0] rpc1;
    logic [0:0]  crn1;
    logic        busy1, done1, to1;
    logic [0:0]  halted1;
    logic [31:0] cc1, rc1;

    // Two-core instance
    logic        start2;
    logic [1:0]  rv2;
    logic [63:0] rpc2;
    logic [1:0]  crn2;
    logic        busy2, done2, to2;
    logic [1:0]  halted2;
    logic [31:0] cc2;
    logic [63:0] rc2;

    pipeline_run_ctrl #(
        .NUM_CORES(1), .RST_HOLD(HOLD), .MAX_CYCLES(MAXC), .HALT_REPEAT(4),
        .PC_W(32), .CNT_W(32)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .retire_valid(rv1), .retire_pc(rpc1),
        .core_rst_n(crn1), .busy(busy1), .done(done1), .timeout(to1),
        .halted(halted1), .cycle_count(cc1), .retire_count(rc1)
    );

    pipeline_run_ctrl #(
        .NUM_CORES(2), .RST_HOLD(HOLD), .MAX_CYCLES(MAXC), .HALT_REPEAT(4),
        .PC_W(32), .CNT_W(32)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .retire_valid(rv2), .retire_pc(rpc2),
        .core_rst_n(crn2), .busy(busy2), .done(done2), .timeout(to2),
        .halted(halted2), .cycle_count(cc2), .retire_count(rc2)
    );

    typedef struct packed {
        logic [31:0]       n;
        logic [0:7][31:0]  pcs;
        logic              exp_to;
        logic              exp_halt;
        logic [31:0]       exp_cyc;
        logic [31:0]       exp_ret;
    } vec_t;

    typedef struct packed {
        logic        exp_to;
        logic [1:0]  exp_halt;
        logic [31:0] exp_cyc;
        logic [31:0] exp_r0;
        logic [31:0] exp_r1;
    } exp2_t;

    vec_t  vecs [7];
    vec_t  exp_q  [$];
    exp2_t exp2_q [$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] n, input logic [0:7][31:0] pcs,
                                input logic to, input logic h,
                                input logic [31:0] cyc, input logic [31:0] ret);
        vec_t v;
        v.n = n; v.pcs = pcs; v.exp_to = to; v.exp_halt = h;
        v.exp_cyc = cyc; v.exp_ret = ret;
        return v;
    endfunction

    // Pulse start, check the on-entry clear, count the cycles core_rst_n stays low.
    // Returns at the negedge of the first Run cycle.
    task automatic start1_run(output int low);
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        chk("clr_cyc1", cc1, 0);
        chk("clr_ret1", rc1, 0);
        chk("clr_halt1", halted1, 0);
        chk("clr_to1", to1, 0);
        chk("hold_busy1", busy1, 1);
        chk("hold_done1", done1, 0);
        low = 0;
        for (int k = 0; k < 10; k++) begin
            if (crn1 === 1'b1) break;
            low++;
            @(negedge clk);
        end
    endtask

    task automatic start2_run(output int low);
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        chk("clr_cyc2", cc2, 0);
        chk("clr_ret2", rc2, 0);
        chk("clr_halt2", halted2, 0);
        chk("clr_to2", to2, 0);
        chk("hold_busy2", busy2, 1);
        chk("hold_done2", done2, 0);
        low = 0;
        for (int k = 0; k < 10; k++) begin
            if (crn2 === 2'b11) break;
            low++;
            @(negedge clk);
        end
    endtask

    // Two-core run: core0 loops on 0x40 in cycles 7..10; core1 retires fresh PCs,
    // or (last_halt) loops on 0x80 in cycles 46..49 so it halts on the final budget cycle.
    task automatic run2(input bit last_halt);
        exp2_t e;
        for (int c = 0; c < 80; c++) begin
            if (done2 === 1'b1) break;
            rv2[0]        = (c >= 7) && (c <= 10);
            rpc2[31:0]    = 32'h40;
            rv2[1]        = 1'b1;
            if (last_halt && (c >= 46)) rpc2[63:32] = 32'h80;
            else rpc2[63:32] = 32'h100 + 32'(4 * c);
            start2        = last_halt && (c == 20);
            @(negedge clk);
        end
        rv2 = '0; start2 = 1'b0;
        e = exp2_q.pop_front();
        chk("done2", done2, 1);
        chk("timeout2", to2, e.exp_to);
        chk("halted2", halted2, e.exp_halt);
        chk("cycles2", cc2, e.exp_cyc);
        chk("ret2_c0", rc2[31:0], e.exp_r0);
        chk("ret2_c1", rc2[63:32], e.exp_r1);
        chk("crn2_done", crn2, 2'b00);
        chk("busy2_done", busy2, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   low;
        vec_t v;

        vecs[0] = mk(0, {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                     1'b1, 1'b0, 50, 0);
        vecs[1] = mk(7, {32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC, 32'hC, 32'h0},
                     1'b0, 1'b1, 7, 7);
        vecs[2] = mk(4, {32'h10, 32'h10, 32'h10, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0},
                     1'b0, 1'b1, 4, 4);
        // Same PC as the previous run's halt: the first retire must restart the streak.
        vecs[3] = mk(3, {32'h10, 32'h10, 32'h10, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
                     1'b1, 1'b0, 50, 3);
        vecs[4] = mk(7, {32'h5, 32'h5, 32'h5, 32'h6, 32'h6, 32'h6, 32'h6, 32'h0},
                     1'b0, 1'b1, 7, 7);
        vecs[5] = mk(7, {32'h20, 32'h20, 32'h20, 32'h24, 32'h20, 32'h20, 32'h20, 32'h0},
                     1'b1, 1'b0, 50, 7);
        // Retires after the halt land in Done and must not be counted.
        vecs[6] = mk(8, {32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1},
                     1'b0, 1'b1, 4, 4);

        rst = 1'b0; start1 = 1'b0; start2 = 1'b0;
        rv1 = '0; rpc1 = '0; rv2 = '0; rpc2 = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_crn1", crn1, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_done1", done1, 0);
        chk("rst_to1", to1, 0);
        chk("rst_halt1", halted1, 0);
        chk("rst_cyc1", cc1, 0);
        chk("rst_ret1", rc1, 0);
        chk("rst_crn2", crn2, 0);
        chk("rst_busy2", busy2, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_busy1", busy1, 0);
        chk("idle_crn1", crn1, 0);

        // Table-driven single-core runs
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(vecs[i]);
            start1_run(low);
            chk("hold_len1", low, HOLD);
            chk("run_busy1", busy1, 1);
            chk("run_done1", done1, 0);
            for (int k = 0; k < int'(vecs[i].n); k++) begin
                rv1 = 1'b1; rpc1 = vecs[i].pcs[k];
                @(negedge clk);
            end
            rv1 = 1'b0; rpc1 = 32'hDEAD_0000;
            for (int w = 0; w < 100; w++) begin
                if (done1 === 1'b1) break;
                @(negedge clk);
            end
            v = exp_q.pop_front();
            chk("done1", done1, 1);
            chk("timeout1", to1, v.exp_to);
            chk("halted1", halted1, v.exp_halt);
            chk("cycles1", cc1, v.exp_cyc);
            chk("retires1", rc1, v.exp_ret);
            chk("busy1_done", busy1, 0);
            chk("crn1_done", crn1, 0);
            @(negedge clk);
            chk("hold_cyc1", cc1, v.exp_cyc);
            chk("hold_lvl1", done1, 1);
        end

        // Two cores, only core0 halts: budget expires
        exp2_q.push_back('{exp_to: 1'b1, exp_halt: 2'b01, exp_cyc: 50, exp_r0: 4, exp_r1: 50});
        start2_run(low);
        chk("hold_len2", low, HOLD);
        run2(1'b0);

        // Restart from Done; core1 halts on the last budget cycle; start in Run ignored
        exp2_q.push_back('{exp_to: 1'b0, exp_halt: 2'b11, exp_cyc: 50, exp_r0: 4, exp_r1: 50});
        start2_run(low);
        chk("hold_len2b", low, HOLD);
        run2(1'b1);

        // Leave dut2 running, then reset both mid-run
        start2_run(low);
        start1_run(low);
        for (int k = 0; k < 5; k++) begin
            rv1 = (k < 3); rpc1 = 32'h30;
            @(negedge clk);
        end
        rv1 = 1'b0;
        chk("pre_rst_cyc1", cc1, 5);
        rst = 1'b0;
        #1;
        chk("mid_rst_crn1", crn1, 0);
        chk("mid_rst_busy1", busy1, 0);
        chk("mid_rst_cyc1", cc1, 0);
        chk("mid_rst_ret1", rc1, 0);
        chk("mid_rst_crn2", crn2, 0);
        chk("mid_rst_busy2", busy2, 0);
        chk("mid_rst_cyc2", cc2, 0);
        chk("mid_rst_ret2", rc2, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("post_rst_busy1", busy1, 0);
        chk("post_rst_crn1", crn1, 0);
        chk("post_rst_done1", done1, 0);
        chk("post_rst_busy2", busy2, 0);
        chk("post_rst_cyc2", cc2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
